seg_share_arbiter: RTL

Round-robin arbiter sharing the board's single 7-segment display (SEG) among NREQ requesters. The winning requester's 4-bit value is latched, decoded to a segment pattern and held for HOLD clk_2 cycles. Grant is exposed one-hot for LED indication. Sits between top-level datapath producers and the SEG/LED outputs of top.

---
 rtl/seg_pkg.sv | 26 ++
 rtl/hex7seg.sv | 33 +++
 rtl/seg_share_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment patterns (bit0=a .. bit6=g, bit7=dp) and arbiter state.
package seg_pkg;

  typedef logic [7:0] seg_t;

  typedef enum logic {IDLE, SHOW} state_t;

  localparam seg_t SEG_OFF = 8'h00;
  localparam seg_t SEG_0   = 8'h3F;
  localparam seg_t SEG_1   = 8'h06;
  localparam seg_t SEG_2   = 8'h5B;
  localparam seg_t SEG_3   = 8'h4F;
  localparam seg_t SEG_4   = 8'h66;
  localparam seg_t SEG_5   = 8'h6D;
  localparam seg_t SEG_6   = 8'h7D;
  localparam seg_t SEG_7   = 8'h07;
  localparam seg_t SEG_8   = 8'h7F;
  localparam seg_t SEG_9   = 8'h6F;
  localparam seg_t SEG_A   = 8'h77;
  localparam seg_t SEG_B   = 8'h7C;
  localparam seg_t SEG_C   = 8'h39;
  localparam seg_t SEG_D   = 8'h5E;
  localparam seg_t SEG_E   = 8'h79;
  localparam seg_t SEG_F   = 8'h71;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex digit to 7-segment decoder, dp always off.
// Zero latency, no handshake.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_share_arbiter.sv
// Round-robin share of one 7-segment display; winner's digit latched and held HOLD cycles.
// Grant and segments valid one edge after req is sampled; losers simply wait (level-sensitive req).
module seg_share_arbiter
  import seg_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int HOLD = 4
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [4*NREQ-1:0]     val,
  output logic [7:0]            seg,
  output logic [3:0]            digit,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [3:0]      digit_q, digit_d;
  seg_t            seg_q, seg_d;
  logic            busy_q, busy_d;
  logic [PW-1:0]   win;
  seg_t            dec;

  // First requester at or after p, wrapping modulo NREQ.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
    logic [PW-1:0] w;
    logic          found;
    int            idx;
    w     = p;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(p) + k) % NREQ;
      if (!found && r[idx]) begin
        w     = PW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign win = rr_pick(req, ptr_q);

  // Decode the value about to be latched so seg is registered alongside digit.
  hex7seg u_dec (
    .hex (digit_d),
    .seg (dec)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    gnt_d   = gnt_q;
    digit_d = digit_q;
    busy_d  = busy_q;
    if (state_q == SHOW && timer_q != '0) begin
      timer_d = timer_q - TW'(1);
    end else if (|req) begin
      state_d = SHOW;
      gnt_d   = NREQ'(1) << win;
      digit_d = val[4*win +: 4];
      busy_d  = 1'b1;
      timer_d = TW'(HOLD - 1);
      ptr_d   = PW'((int'(win) + 1) % NREQ);
    end else begin
      state_d = IDLE;
      gnt_d   = '0;
      digit_d = 4'h0;
      busy_d  = 1'b0;
      timer_d = '0;
    end
    seg_d = busy_d ? dec : SEG_OFF;
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      timer_q <= '0;
      gnt_q   <= '0;
      digit_q <= 4'h0;
      seg_q   <= SEG_OFF;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      gnt_q   <= gnt_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
      busy_q  <= busy_d;
    end
  end

  assign seg   = seg_q;
  assign digit = digit_q;
  assign gnt   = gnt_q;
  assign busy  = busy_q;

endmodule
